// File: rtl/button_conditioner.sv
// Purpose: synchronize, debounce and edge-detect four raw pushbuttons into one-hot step pulses with auto-repeat.
// Latency: a press sampled at edge 0 moves btn_level at edge DEBOUNCE_CYCLES+1 and pulses at edge DEBOUNCE_CYCLES+2.
// Backpressure: none; fixed priority U > D > L > R, and losing requests are dropped rather than queued.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 15000000,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnL,
  input  logic       btnR,
  output logic       btnU_pulse,
  output logic       btnD_pulse,
  output logic       btnL_pulse,
  output logic       btnR_pulse,
  output logic [3:0] btn_level
);

  // Channel index map: 3 = up, 2 = down, 1 = left, 0 = right.
  // Higher index means higher arbitration priority.
  localparam int unsigned NCH  = 4;
  localparam int unsigned CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = $clog2(RMAX + 1);

  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);
  localparam logic [RW-1:0] RC_ONE   = RW'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } ch_state_e;

  logic [NCH-1:0] btn_raw;

  logic [NCH-1:0] sync1_q, sync1_d;
  logic [NCH-1:0] sync2_q, sync2_d;
  logic [NCH-1:0] level_q, level_d;
  logic [NCH-1:0] pulse_q, pulse_d;
  logic [NCH-1:0] req;

  logic [CW-1:0]  cnt_q   [NCH];
  logic [CW-1:0]  cnt_d   [NCH];
  logic [RW-1:0]  rc_q    [NCH];
  logic [RW-1:0]  rc_d    [NCH];
  ch_state_e      state_q [NCH];
  ch_state_e      state_d [NCH];

  assign btn_raw = {btnU, btnD, btnL, btnR};

  // Two-flop synchronizer per button; sync2 is the first usable level.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
  end

  // Debounce: the synchronized level must differ from the held level for
  // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        level_d[i] = sync2_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Per-channel press / auto-repeat FSM. Every state falls back to IDLE the
  // cycle the debounced level is low, so IDLE with level high is exactly a
  // debounced rising edge. Release wins over a same-cycle repeat tick.
  always_comb begin
    req = '0;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      rc_d[i]    = rc_q[i];
      if (!level_q[i]) begin
        state_d[i] = ST_IDLE;
        rc_d[i]    = '0;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            req[i]     = 1'b1;
            state_d[i] = ST_DELAY;
            rc_d[i]    = '0;
          end
          ST_DELAY: begin
            // With repeat disabled the channel parks here until release.
            if (REPEAT_EN) begin
              if (rc_q[i] == DLY_LAST) begin
                req[i]     = 1'b1;
                rc_d[i]    = '0;
                state_d[i] = ST_REPEAT;
              end else begin
                rc_d[i] = rc_q[i] + RC_ONE;
              end
            end
          end
          ST_REPEAT: begin
            if (rc_q[i] == PER_LAST) begin
              req[i]  = 1'b1;
              rc_d[i] = '0;
            end else begin
              rc_d[i] = rc_q[i] + RC_ONE;
            end
          end
          default: begin
            state_d[i] = ST_IDLE;
            rc_d[i]    = '0;
          end
        endcase
      end
    end
  end

  // Fixed-priority arbiter: at most one step per cycle, losers are dropped.
  always_comb begin
    pulse_d = '0;
    if (req[3]) begin
      pulse_d[3] = 1'b1;
    end else if (req[2]) begin
      pulse_d[2] = 1'b1;
    end else if (req[1]) begin
      pulse_d[1] = 1'b1;
    end else if (req[0]) begin
      pulse_d[0] = 1'b1;
    end
  end

  // State registers with synchronous reset; reset aborts any press in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      pulse_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]   <= '0;
        rc_q[i]    <= '0;
        state_q[i] <= ST_IDLE;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]   <= cnt_d[i];
        rc_q[i]    <= rc_d[i];
        state_q[i] <= state_d[i];
      end
    end
  end

  assign btnU_pulse = pulse_q[3];
  assign btnD_pulse = pulse_q[2];
  assign btnL_pulse = pulse_q[1];
  assign btnR_pulse = pulse_q[0];
  assign btn_level  = level_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: expected step pulses are queued with
// their absolute cycle when a button is driven and matched every cycle.
// Second instance has auto-repeat disabled.
module tb_button_conditioner;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  typedef struct {
    int         cyc;
    logic [3:0] vec;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       btnU, btnD, btnL, btnR;
  logic       btnU_pulse, btnD_pulse, btnL_pulse, btnR_pulse;
  logic [3:0] btn_level;

  logic       nr_btnU;
  logic       nr_U_pulse, nr_D_pulse, nr_L_pulse, nr_R_pulse;
  logic [3:0] nr_level;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  exp_t exp_q[$];
  exp_t nr_q[$];
  exp_t e_m, e_n;
  logic [3:0] pv_m, pv_n;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR),
    .btnU_pulse(btnU_pulse), .btnD_pulse(btnD_pulse),
    .btnL_pulse(btnL_pulse), .btnR_pulse(btnR_pulse),
    .btn_level(btn_level)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_EN(1'b0)
  ) dut_nr (
    .clk(clk), .rst(rst),
    .btnU(nr_btnU), .btnD(1'b0), .btnL(1'b0), .btnR(1'b0),
    .btnU_pulse(nr_U_pulse), .btnD_pulse(nr_D_pulse),
    .btnL_pulse(nr_L_pulse), .btnR_pulse(nr_R_pulse),
    .btn_level(nr_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: each cycle the observed pulse vector must equal the queued
  // expectation for that cycle, or all zeros when nothing is due.
  always @(negedge clk) begin
    if (mon_en) begin
      pv_m = {btnU_pulse, btnD_pulse, btnL_pulse, btnR_pulse};
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e_m = exp_q.pop_front();
        checks++;
        assert (pv_m === e_m.vec) else begin
          errors++;
          $error("FAIL pulse_expected cyc=%0d observed=%b expected=%b", cyc, pv_m, e_m.vec);
        end
      end else begin
        checks++;
        assert (pv_m === 4'b0000) else begin
          errors++;
          $error("FAIL pulse_idle cyc=%0d observed=%b expected=%b", cyc, pv_m, 4'b0000);
        end
      end

      pv_n = {nr_U_pulse, nr_D_pulse, nr_L_pulse, nr_R_pulse};
      if (nr_q.size() > 0 && nr_q[0].cyc == cyc) begin
        e_n = nr_q.pop_front();
        checks++;
        assert (pv_n === e_n.vec) else begin
          errors++;
          $error("FAIL nr_pulse_expected cyc=%0d observed=%b expected=%b", cyc, pv_n, e_n.vec);
        end
      end else begin
        checks++;
        assert (pv_n === 4'b0000) else begin
          errors++;
          $error("FAIL nr_pulse_idle cyc=%0d observed=%b expected=%b", cyc, pv_n, 4'b0000);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) tick();
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, expv);
    end
  endtask

  // Button driven high right after cycle c: first pulse at c+DB+3, then
  // RD later, then every RP, keeping only pulses at or before 'last'.
  task automatic push_hold(input logic [3:0] vec, input int c, input int last);
    int p;
    exp_t e;
    p = c + DB + 3;
    e.vec = vec;
    while (p <= last) begin
      e.cyc = p;
      exp_q.push_back(e);
      p = (p == c + DB + 3) ? p + RD : p + RP;
    end
  endtask

  initial begin
    int c;
    exp_t en;

    rst = 1'b1;
    btnU = 1'b0; btnD = 1'b0; btnL = 1'b0; btnR = 1'b0;
    nr_btnU = 1'b0;
    repeat (3) tick();
    chk("reset_level", btn_level, 4'b0000);
    chk("reset_pulses", {btnU_pulse, btnD_pulse, btnL_pulse, btnR_pulse}, 4'b0000);
    chk("reset_nr_level", nr_level, 4'b0000);
    rst = 1'b0;
    tick();
    mon_en = 1'b1;

    // Up held, released so the debounced fall lands on the repeat tick.
    c = cyc;
    btnU = 1'b1;
    push_hold(4'b1000, c, c + 25 + DB + 2);
    wait_until(c + 5);
    chk("t1_level_before", btn_level, 4'b0000);
    wait_until(c + 6);
    chk("t1_level_rise", btn_level, 4'b1000);
    wait_until(c + 25);
    btnU = 1'b0;
    wait_until(c + 30);
    chk("t1_level_still_high", btn_level, 4'b1000);
    wait_until(c + 31);
    chk("t1_level_fall", btn_level, 4'b0000);
    wait_until(c + 45);

    // Release two cycles after first repeat pulse, then a fresh re-press.
    c = cyc;
    btnU = 1'b1;
    push_hold(4'b1000, c, c + 19 + DB + 2);
    wait_until(c + 19);
    btnU = 1'b0;
    wait_until(c + 25);
    chk("t5_level_released", btn_level, 4'b0000);
    wait_until(c + 40);
    c = cyc;
    btnU = 1'b1;
    push_hold(4'b1000, c, c + 10 + DB + 2);
    wait_until(c + 10);
    btnU = 1'b0;
    wait_until(c + 30);

    // Bounce on left: 1,0,1,1,0 then steady 1.
    c = cyc;
    btnL = 1'b1; tick();
    btnL = 1'b0; tick();
    btnL = 1'b1; tick();
    btnL = 1'b1; tick();
    btnL = 1'b0; tick();
    btnL = 1'b1;
    push_hold(4'b0010, c + 5, c + 13 + DB + 2);
    for (int k = 5; k <= 10; k++) begin
      wait_until(c + k);
      chk("t2_level_bounce", btn_level, 4'b0000);
    end
    wait_until(c + 11);
    chk("t2_level_settled", btn_level, 4'b0010);
    wait_until(c + 13);
    btnL = 1'b0;
    wait_until(c + 35);

    // Right glitch of DB-1 cycles: level never moves.
    c = cyc;
    btnR = 1'b1;
    wait_until(c + DB - 1);
    btnR = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      wait_until(c + k);
      chk("t3_glitch_level", btn_level, 4'b0000);
    end
    wait_until(c + 20);

    // Down and right together; right is dropped, then released early.
    c = cyc;
    btnD = 1'b1;
    btnR = 1'b1;
    push_hold(4'b0100, c, c + 14 + DB + 2);
    wait_until(c + 6);
    chk("t4_level_both", btn_level, 4'b0101);
    wait_until(c + 10);
    btnR = 1'b0;
    wait_until(c + 14);
    btnD = 1'b0;
    wait_until(c + 16);
    chk("t4_level_r_released", btn_level, 4'b0100);
    wait_until(c + 40);

    // Reset while left is in auto-repeat; held button re-debounces.
    c = cyc;
    btnL = 1'b1;
    push_hold(4'b0010, c, c + 24);
    wait_until(c + 24);
    chk("t6_level_held", btn_level, 4'b0010);
    rst = 1'b1;
    tick();
    chk("t6_reset_level", btn_level, 4'b0000);
    chk("t6_reset_pulses", {btnU_pulse, btnD_pulse, btnL_pulse, btnR_pulse}, 4'b0000);
    rst = 1'b0;
    push_hold(4'b0010, c + 25, c + 45 + DB + 2);
    wait_until(c + 45);
    btnL = 1'b0;
    wait_until(c + 70);

    // Repeat disabled: one pulse for a 40-cycle hold.
    c = cyc;
    nr_btnU = 1'b1;
    en.cyc = c + DB + 3;
    en.vec = 4'b1000;
    nr_q.push_back(en);
    wait_until(c + 6);
    chk("t6b_nr_level", nr_level, 4'b1000);
    wait_until(c + 40);
    nr_btnU = 1'b0;
    wait_until(c + 60);
    chk("t6b_nr_level_released", nr_level, 4'b0000);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end
    checks++;
    assert (nr_q.size() == 0) else begin
      errors++;
      $error("FAIL nr_scoreboard_drain observed=%0d expected=0", nr_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Upstream front end for the movement stage. Takes the four raw, asynchronous, bouncy pushbuttons (up/down/left/right), then synchronizes, debounces and edge-detects them. It drives single-cycle, mutually exclusive step pulses into the position-update stage. Holding a direction auto-repeats its pulse, so holding a button keeps the position moving.

Parameters:
DEBOUNCE_CYCLES, 500000, cycles a synchronized level must stay stable before the debounced level changes (5 ms at 100 MHz); must be >= 1
REPEAT_DELAY, 50000000, cycles from the first pulse to the first auto-repeat pulse while the button is held
REPEAT_PERIOD, 15000000, cycles between later auto-repeat pulses; must be >= 1
REPEAT_EN, 1, 1 = auto-repeat enabled; 0 = exactly one pulse per press

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  synchronous, active-high reset
btnU  in  1  raw up button, asynchronous
btnD  in  1  raw down button, asynchronous
btnL  in  1  raw left button, asynchronous
btnR  in  1  raw right button, asynchronous
btnU_pulse  out  1  one-cycle up step, registered
btnD_pulse  out  1  one-cycle down step, registered
btnL_pulse  out  1  one-cycle left step, registered
btnR_pulse  out  1  one-cycle right step, registered
btn_level  out  4  debounced levels {U,D,L,R}, registered

Behaviour:
- Reset: all pulses = 0, btn_level = 0, synchronizer flops = 0, all counters = 0, every channel FSM = IDLE. Reset applied mid-press aborts the press. After reset is released, a button still held is re-debounced and pulses again as a fresh press.
- Synchronizer: two flops per button; s2 is the synchronized level.
- Debounce, per channel, with counter cnt of width clog2(DEBOUNCE_CYCLES+1):
  - If s2 == level: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: level <= s2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any glitch shorter than DEBOUNCE_CYCLES resets the count, so level does not change.
- Latency: the raw input is first sampled at edge 0. The debounced level changes at edge DEBOUNCE_CYCLES+1. The step pulse is high for exactly one cycle, starting at edge DEBOUNCE_CYCLES+2.
- Channel FSM, per button, with repeat counter rc of width clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1):
  - IDLE: on a debounced rising edge, raise the request and go to DELAY with rc = 0.
  - DELAY: rc increments each cycle. When rc == REPEAT_DELAY-1, raise the request, set rc = 0 and go to REPEAT. If REPEAT_EN = 0, stay in DELAY and never request.
  - REPEAT: rc increments each cycle. When rc == REPEAT_PERIOD-1, raise the request and set rc = 0.
  - Any state: when the debounced level is 0, go to IDLE with rc = 0 (release takes priority over a same-cycle repeat tick, so no pulse is issued).
- Arbitration:
  - Requests are combinational; outputs are registered from the arbiter.
  - Fixed priority U > D > L > R, matching the downstream priority.
  - Exactly one pulse at most is high in any cycle.
  - Lower-priority requests raised in the same cycle are dropped, not queued. Their FSMs still advance, so their repeat timing is unaffected.
- Simultaneous presses: each channel debounces independently. Opposite directions held together give pulses only for the higher-priority button on cycles where both request.
- No pulse is ever generated on a release (falling edge).
- Counters saturate nowhere and wrap nowhere, because every count is bounded by a compare-and-clear.

Test Plan:
(Parameters for all cases: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, REPEAT_EN=1.)
1. Reset, then btnU held high from edge 0 -> btn_level[3] rises at edge 5; btnU_pulse is high only in the cycle after edge 6. The next pulses occur 10 cycles later, then every 5 cycles while held; no other pulse outputs toggle.
2. Bounce: btnL toggles 1,0,1,1,0,1 on successive cycles, then stays at 1 -> no pulse during the bounce. Exactly one btnL_pulse 6 cycles after the last 0→1 transition.
3. Glitch: btnR high for 3 cycles, then low -> btn_level[0] stays 0; btnR_pulse is never asserted.
4. Simultaneous press: btnD and btnR rise on the same edge -> btnD_pulse fires and btnR_pulse does not (dropped). If btnR is released while btnD is held, btnR gives no later pulse.
5. Release: btnU held until 2 cycles after its first repeat pulse, then released -> no further pulses. After DEBOUNCE_CYCLES+1 edges, btn_level[3]=0 and the FSM is in IDLE. A re-press produces a first pulse after the full latency.
6. Reset mid-hold: assert rst for 1 cycle while btnL is in REPEAT -> all outputs are 0 during the reset cycle. With btnL still high, a new first pulse arrives 6 edges after reset deasserts. A separate run with REPEAT_EN=0 and a 40-cycle hold gives exactly one pulse.
